// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Definitions shared by the BNN accelerator blocks:
//   INST_COMPUTE / INST_LOADIFMAPS : instruction codes seen on axi_control_0
//   load_state_e                   : ifmap loader FSM states
//   calc_beats()                   : stream beats needed to fill one BRAM word
//   cnt_width()                    : counter width for a 0..n-1 range (min 1)
// ---------------------------------------------------------------------------
package bnn_pkg;

  localparam logic [31:0] INST_COMPUTE    = 32'd87;
  localparam logic [31:0] INST_LOADIFMAPS = 32'd88;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_DONE
  } load_state_e;

  function automatic int calc_beats(input int word_w, input int beat_w);
    return word_w / beat_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifmap_stream_loader_if.sv
// ---------------------------------------------------------------------------
// ifmap_stream_loader_if
// Bundles the AXI-Stream slave beat channel and BRAM port A write channel of
// the ifmap loader.
//   s_axis_tdata/tvalid/tlast : stream beat, driven by the stream source
//   s_axis_tready             : beat accepted, driven by the loader
//   bram_address/din/en/we    : BRAM port A write, driven by the loader
// Modports: slave = the loader, master = the stream source / environment.
// ---------------------------------------------------------------------------
interface ifmap_stream_loader_if #(
  parameter int TDATA_W = 32,
  parameter int DATA_W  = 1280,
  parameter int ADDR_W  = 12
);

  logic [TDATA_W-1:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               s_axis_tlast;

  logic [ADDR_W-1:0]  bram_address;
  logic [DATA_W-1:0]  bram_din;
  logic               bram_en;
  logic               bram_we;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output bram_address, bram_din, bram_en, bram_we
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  bram_address, bram_din, bram_en, bram_we
  );

endinterface

// File: rtl/axis_beat_packer.sv
// ---------------------------------------------------------------------------
// axis_beat_packer
// Packs narrow stream beats into one wide word, beat 0 in the LSBs.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : zero the word and restart at slot 0 (wins over load_i)
//   load_i     : store data_i into the current slot and advance
//   data_i     : beat data
//   word_o     : packed word; unfilled slots read as zero
//   full_o     : current slot is the last one (next load completes the word)
// ---------------------------------------------------------------------------
module axis_beat_packer
  import bnn_pkg::*;
#(
  parameter int TDATA_W = 32,
  parameter int DATA_W  = 1280
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [TDATA_W-1:0] data_i,
  output logic [DATA_W-1:0]  word_o,
  output logic               full_o
);

  localparam int BEATS = calc_beats(DATA_W, TDATA_W);
  localparam int CNT_W = cnt_width(BEATS);

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  assign full_o = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign word_o = word_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned -- that is what keeps latches from being inferred.
    beat_cnt_d = beat_cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      beat_cnt_d = '0;
      word_d     = '0;
    end else if (load_i) begin
      word_d[int'(beat_cnt_q)*TDATA_W +: TDATA_W] = data_i;
      beat_cnt_d = full_o ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // NOTE: the packing word is ordinary flops, not a RAM, so it takes the
  // async reset; a reset mid-load therefore discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: rtl/ifmap_stream_loader.sv
// ---------------------------------------------------------------------------
// ifmap_stream_loader
// AXI-Stream ingress stage: on an INST_LOADIFMAPS instruction it packs
// 32-bit beats into BRAM-width words and writes them one per write cycle on
// BRAM port A, then reports done / tlast-mismatch error.
//   clk, rst_n     : clock, asynchronous active-low reset
//   axi_control_0  : instruction word; a rising match to 88 starts a load
//   load_base_addr : first BRAM address to write
//   load_length    : number of BRAM words to load (0 = no writes)
//   bus            : stream slave + BRAM port A (ifmap_stream_loader_if.slave)
//   load_busy      : high whenever the FSM is not idle
//   load_done      : one-cycle completion pulse
//   load_error     : sticky tlast-mismatch flag, cleared on the next start
// All bus/status outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module ifmap_stream_loader
  import bnn_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH      = 1280,
  parameter int BRAM_ADDRESS_WIDTH   = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 axi_control_0,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] load_base_addr,
  input  logic [BRAM_ADDRESS_WIDTH:0]   load_length,
  ifmap_stream_loader_if.slave        bus,
  output logic                        load_busy,
  output logic                        load_done,
  output logic                        load_error
);

  localparam int AW = BRAM_ADDRESS_WIDTH;

  load_state_e state_q, state_d;

  logic          inst_match;
  logic          inst_prev_q;
  logic          start;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   word_cnt_q;
  logic          error_q;
  logic          term_q;     // early tlast seen: this write is the last one

  logic                       hs;
  logic                       last_word;
  logic                       early_last;
  logic                       missing_last;
  logic                       pack_full;
  logic                       pack_clear;
  logic [BRAM_DATA_WIDTH-1:0] pack_word;

  // Start only on the cycle the instruction first appears, so a held
  // instruction word does not retrigger the load.
  assign inst_match = (axi_control_0 == INST_LOADIFMAPS);
  assign start      = inst_match && !inst_prev_q;

  assign hs           = (state_q == LD_RECV) && bus.s_axis_tvalid;
  assign last_word    = (word_cnt_q == len_q - (AW+1)'(1));
  assign early_last   = hs && bus.s_axis_tlast && !(pack_full && last_word);
  assign missing_last = hs && !bus.s_axis_tlast && pack_full && last_word;

  // Cleared on start and in every write cycle, so each word begins all-zero
  // and an early-terminated word carries zeros in its unfilled slots.
  assign pack_clear = ((state_q == LD_IDLE) && start) || (state_q == LD_WRITE);

  axis_beat_packer #(
    .TDATA_W (C_S_AXIS_TDATA_WIDTH),
    .DATA_W  (BRAM_DATA_WIDTH)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (pack_clear),
    .load_i  (hs),
    .data_i  (bus.s_axis_tdata),
    .word_o  (pack_word),
    .full_o  (pack_full)
  );

  // ---- FSM: state register ------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LD_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE:  if (start) state_d = (load_length == '0) ? LD_DONE : LD_RECV;
      LD_RECV:  if (hs && (pack_full || bus.s_axis_tlast)) state_d = LD_WRITE;
      LD_WRITE: state_d = (last_word || term_q) ? LD_DONE : LD_RECV;
      LD_DONE:  state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  // ---- FSM: outputs (registered state only) -------------------------------
  always_comb begin
    bus.s_axis_tready = (state_q == LD_RECV);
    bus.bram_en       = (state_q == LD_WRITE);
    bus.bram_we       = (state_q == LD_WRITE);
    bus.bram_address  = '0;
    bus.bram_din      = '0;
    if (state_q == LD_WRITE) begin
      bus.bram_address = base_q + word_cnt_q[AW-1:0];  // wraps mod 2^AW
      bus.bram_din     = pack_word;
    end
    load_busy = (state_q != LD_IDLE);
    load_done = (state_q == LD_DONE);
  end

  assign load_error = error_q;

  // ---- Load context and status --------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_prev_q <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      error_q     <= 1'b0;
      term_q      <= 1'b0;
    end else begin
      inst_prev_q <= inst_match;
      if ((state_q == LD_IDLE) && start) begin
        base_q     <= load_base_addr;
        len_q      <= load_length;
        word_cnt_q <= '0;
        error_q    <= 1'b0;
        term_q     <= 1'b0;
      end
      if (early_last || missing_last) error_q <= 1'b1;
      if (early_last)                 term_q  <= 1'b1;
      if ((state_q == LD_WRITE) && !(last_word || term_q))
        word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifmap_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_ifmap_stream_loader
// Directed self-checking bench for ifmap_stream_loader. Inputs change and
// outputs are sampled on the falling clock edge; a passive monitor records
// every BRAM write and load_done pulse.
// ---------------------------------------------------------------------------
module tb_ifmap_stream_loader;
  import bnn_pkg::*;

  localparam int TW = 32;
  localparam int DW = 1280;
  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic [31:0]   axi_control_0;
  logic [AW-1:0] load_base_addr;
  logic [AW:0]   load_length;
  logic          load_busy;
  logic          load_done;
  logic          load_error;

  ifmap_stream_loader_if #(.TDATA_W(TW), .DATA_W(DW), .ADDR_W(AW)) bus ();

  ifmap_stream_loader #(
    .C_S_AXIS_TDATA_WIDTH (TW),
    .BRAM_DATA_WIDTH      (DW),
    .BRAM_ADDRESS_WIDTH   (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axi_control_0  (axi_control_0),
    .load_base_addr (load_base_addr),
    .load_length    (load_length),
    .bus            (bus),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---- monitor --------------------------------------------------------------
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            done_cnt = 0;
  int            tready_in_write = 0;

  always @(negedge clk) begin
    if (bus.bram_we === 1'b1) begin
      wr_addr_q.push_back(bus.bram_address);
      wr_data_q.push_back(bus.bram_din);
      if (bus.s_axis_tready === 1'b1) tready_in_write++;
    end
    if (load_done === 1'b1) done_cnt++;
  end

  // ---- helpers --------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    int k;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      k = 0;
      while (k < DW/TW - 1 && obs[k*TW +: TW] === exp[k*TW +: TW]) k++;
      $error("FAIL %s slot %0d observed=%0h expected=%0h", tag, k, obs[k*TW +: TW], exp[k*TW +: TW]);
    end
  endtask

  function automatic logic [DW-1:0] make_word(input logic [31:0] seed, input int nfill);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < nfill; i++) w[i*TW +: TW] = seed + i;
    return w;
  endfunction

  task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] l);
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    tready_in_write = 0;
    @(negedge clk);
    axi_control_0  = INST_LOADIFMAPS;
    load_base_addr = b;
    load_length    = l;
    @(negedge clk);
    axi_control_0  = 32'd0;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    int guard;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    guard = 0;
    while (bus.s_axis_tready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("tready_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_range(input logic [31:0] seed, input int n, input int last_idx, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat (i % 3) begin
          @(negedge clk);
          bus.s_axis_tvalid = 1'b0;
        end
      end
      push_beat(seed + i, (i == last_idx));
    end
  endtask

  // Final beat has been presented with tready high; checks the write cycle,
  // the done pulse one cycle later, and busy dropping the cycle after that.
  task automatic finish_check(input string tag, input logic [AW-1:0] exp_addr);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check({tag, "_we"},     bus.bram_we, 1);
    check({tag, "_tready"}, bus.s_axis_tready, 0);
    check({tag, "_addr"},   bus.bram_address, exp_addr);
    @(negedge clk);
    check({tag, "_done"},   load_done, 1);
    check({tag, "_busy1"},  load_busy, 1);
    @(negedge clk);
    check({tag, "_done0"},  load_done, 0);
    check({tag, "_busy0"},  load_busy, 0);
    @(posedge clk);
    #1;
  endtask

  // ---- directed sequence ----------------------------------------------------
  initial begin
    logic [DW-1:0] w;

    rst_n             = 1'b0;
    axi_control_0     = 32'd0;
    load_base_addr    = '0;
    load_length       = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tready", bus.s_axis_tready, 0);
    check("rst_en",     bus.bram_en, 0);
    check("rst_we",     bus.bram_we, 0);
    check("rst_addr",   bus.bram_address, 0);
    check_word("rst_din", bus.bram_din, '0);
    check("rst_busy",   load_busy, 0);
    check("rst_done",   load_done, 0);
    check("rst_error",  load_error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load: 2 words at 0x010, tdata = beat index, tlast on beat 79
    start_load(12'h010, 13'd2);
    check("basic_start_tready", bus.s_axis_tready, 1);
    check("basic_start_busy",   load_busy, 1);
    push_range(32'd0, 40, -1, 1'b0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    check("basic_w0_we",     bus.bram_we, 1);
    check("basic_w0_en",     bus.bram_en, 1);
    check("basic_w0_tready", bus.s_axis_tready, 0);
    check("basic_w0_addr",   bus.bram_address, 12'h010);
    @(negedge clk);
    check("basic_w0_tready_back", bus.s_axis_tready, 1);
    check("basic_w0_we_off",      bus.bram_we, 0);
    push_range(32'd40, 40, 39, 1'b0);
    finish_check("basic", 12'h011);
    check("basic_nwrites", wr_addr_q.size(), 2);
    check("basic_addr0",   wr_addr_q[0], 12'h010);
    check("basic_addr1",   wr_addr_q[1], 12'h011);
    w = wr_data_q[0];
    check("basic_w0_lsb",  w[31:0], 32'd0);
    check("basic_w0_msb",  w[1279:1248], 32'd39);
    check_word("basic_w0", wr_data_q[0], make_word(32'd0, 40));
    check_word("basic_w1", wr_data_q[1], make_word(32'd40, 40));
    check("basic_done_cnt", done_cnt, 1);
    check("basic_error",    load_error, 0);

    // Backpressure: tvalid gaps over a 1-word load
    start_load(12'h100, 13'd1);
    push_range(32'hA000_0000, 40, 39, 1'b1);
    finish_check("bp", 12'h100);
    check("bp_nwrites", wr_addr_q.size(), 1);
    check_word("bp_word", wr_data_q[0], make_word(32'hA000_0000, 40));
    check("bp_tready_in_write", tready_in_write, 0);
    check("bp_error", load_error, 0);

    // Address wrap: base 0xFFF, 2 words
    start_load(12'hFFF, 13'd2);
    push_range(32'h5555_0000, 80, 79, 1'b0);
    finish_check("wrap", 12'h000);
    check("wrap_nwrites", wr_addr_q.size(), 2);
    check("wrap_addr0",   wr_addr_q[0], 12'hFFF);
    check("wrap_addr1",   wr_addr_q[1], 12'h000);
    check_word("wrap_w1", wr_data_q[1], make_word(32'h5555_0028, 40));

    // Early tlast on beat 5 of a 2-word load
    start_load(12'h020, 13'd2);
    push_range(32'h0000_0100, 6, 5, 1'b0);
    finish_check("early", 12'h020);
    check("early_nwrites", wr_addr_q.size(), 1);
    check_word("early_word", wr_data_q[0], make_word(32'h0000_0100, 6));
    check("early_error", load_error, 1);
    check("early_done_cnt", done_cnt, 1);

    // Missing tlast; start also clears the sticky error
    start_load(12'h030, 13'd1);
    check("miss_error_cleared", load_error, 0);
    push_range(32'hC000_0000, 40, -1, 1'b0);
    finish_check("miss", 12'h030);
    check("miss_nwrites", wr_addr_q.size(), 1);
    check_word("miss_word", wr_data_q[0], make_word(32'hC000_0000, 40));
    check("miss_error", load_error, 1);

    // Start while busy is ignored
    start_load(12'h200, 13'd1);
    push_range(32'hB000_0000, 10, -1, 1'b0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    axi_control_0  = INST_LOADIFMAPS;
    load_base_addr = 12'h300;
    load_length    = 13'd0;
    @(negedge clk);
    axi_control_0  = 32'd0;
    check("restart_busy",   load_busy, 1);
    check("restart_tready", bus.s_axis_tready, 1);
    check("restart_done",   load_done, 0);
    push_range(32'hB000_000A, 30, 29, 1'b0);
    finish_check("restart", 12'h200);
    check("restart_nwrites", wr_addr_q.size(), 1);
    check_word("restart_word", wr_data_q[0], make_word(32'hB000_0000, 40));
    check("restart_done_cnt", done_cnt, 1);

    // Zero length: done the cycle after start, no writes
    start_load(12'h000, 13'd0);
    check("zero_done",   load_done, 1);
    check("zero_busy",   load_busy, 1);
    check("zero_tready", bus.s_axis_tready, 0);
    check("zero_we",     bus.bram_we, 0);
    @(negedge clk);
    check("zero_done0",  load_done, 0);
    check("zero_busy0",  load_busy, 0);
    @(posedge clk);
    #1;
    check("zero_nwrites", wr_addr_q.size(), 0);
    check("zero_done_cnt", done_cnt, 1);

    // Reset mid-load after 20 beats
    start_load(12'h040, 13'd1);
    push_range(32'hD000_0000, 20, -1, 1'b0);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_tready", bus.s_axis_tready, 0);
    check("mrst_we",     bus.bram_we, 0);
    check("mrst_en",     bus.bram_en, 0);
    check("mrst_addr",   bus.bram_address, 0);
    check_word("mrst_din", bus.bram_din, '0);
    check("mrst_busy",   load_busy, 0);
    check("mrst_done",   load_done, 0);
    check("mrst_error",  load_error, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_nwrites", wr_addr_q.size(), 0);

    // Clean reload after the reset
    start_load(12'h041, 13'd1);
    check("reload_tready", bus.s_axis_tready, 1);
    push_range(32'd7, 40, 39, 1'b0);
    finish_check("reload", 12'h041);
    check("reload_nwrites", wr_addr_q.size(), 1);
    check_word("reload_word", wr_data_q[0], make_word(32'd7, 40));
    check("reload_error", load_error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
